// File: rtl/iob_eth_mii_rx_gen.sv
// Simulation-side MII receive frame generator: turns a byte stream into nibble-wide
// rxd/rx_dv/rx_er signalling with preamble, SFD, optional pad, FCS and inter-frame gap.
module iob_eth_mii_rx_gen #(
  parameter int unsigned PAD_EN  = 1,
  parameter int unsigned IFG_NIB = 24
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  input  logic        s_last_i,
  output logic        s_ready_o,
  output logic [3:0]  mii_rxd_o,
  output logic        mii_rx_dv_o,
  output logic        mii_rx_er_o,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o,
  output logic        underrun_o
);

  typedef enum logic [2:0] {
    StIdle, StPre, StPayLo, StPayHi, StPad, StFcs, StIfg
  } state_e;

  localparam logic [31:0] CrcPoly  = 32'hEDB88320;
  localparam logic [15:0] MinBytes = 16'd60;
  localparam logic [15:0] IfgLast  = 16'(IFG_NIB - 1);
  // An aborted frame spends one extra IFG cycle showing the error nibble.
  localparam logic [15:0] IfgAbort = 16'(IFG_NIB);

  function automatic logic [31:0] crc_nib(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc ^ {28'd0, nib};
    for (int i = 0; i < 4; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  nib_cnt_q, nib_cnt_d;
  logic [15:0] ifg_cnt_q, ifg_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d;
  logic        pad_hi_q, pad_hi_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]  rxd_q, rxd_d;
  logic        dv_q, dv_d;
  logic        er_q, er_d;
  logic        und_q, und_d;

  logic        fetch;
  logic [31:0] fcs;
  logic [3:0]  nib_nxt;
  logic [15:0] byte_inc;

  assign fetch    = ((state_q == StPre) && (nib_cnt_q == 4'd15)) ||
                    ((state_q == StPayHi) && !last_q);
  assign fcs      = ~crc_q;
  assign nib_nxt  = nib_cnt_q + 4'd1;
  assign byte_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    nib_cnt_d   = nib_cnt_q;
    ifg_cnt_d   = ifg_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    data_d      = data_q;
    last_d      = last_q;
    pad_hi_d    = pad_hi_q;
    frame_cnt_d = frame_cnt_q;
    rxd_d       = 4'h0;
    dv_d        = 1'b0;
    er_d        = 1'b0;
    und_d       = 1'b0;

    if (fetch) begin
      if (s_valid_i) begin
        data_d  = s_data_i;
        last_d  = s_last_i;
        state_d = StPayLo;
        rxd_d   = s_data_i[3:0];
        dv_d    = 1'b1;
        crc_d   = crc_nib(crc_q, s_data_i[3:0]);
      end else begin
        state_d   = StIfg;
        ifg_cnt_d = IfgAbort;
        dv_d      = 1'b1;
        er_d      = 1'b1;
        und_d     = 1'b1;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (s_valid_i) begin
            state_d    = StPre;
            nib_cnt_d  = 4'd0;
            crc_d      = 32'hFFFFFFFF;
            byte_cnt_d = 16'd0;
            rxd_d      = 4'h5;
            dv_d       = 1'b1;
          end
        end
        StPre: begin
          nib_cnt_d = nib_nxt;
          rxd_d     = (nib_cnt_q == 4'd14) ? 4'hD : 4'h5;
          dv_d      = 1'b1;
        end
        StPayLo: begin
          state_d    = StPayHi;
          rxd_d      = data_q[7:4];
          dv_d       = 1'b1;
          crc_d      = crc_nib(crc_q, data_q[7:4]);
          byte_cnt_d = byte_inc;
        end
        StPayHi: begin
          // Only the last byte reaches here; earlier bytes take the fetch path.
          dv_d = 1'b1;
          if ((PAD_EN != 0) && (byte_cnt_q < MinBytes)) begin
            state_d  = StPad;
            pad_hi_d = 1'b0;
            crc_d    = crc_nib(crc_q, 4'h0);
          end else begin
            state_d   = StFcs;
            nib_cnt_d = 4'd0;
            rxd_d     = fcs[3:0];
          end
        end
        StPad: begin
          dv_d = 1'b1;
          if (!pad_hi_q) begin
            pad_hi_d   = 1'b1;
            crc_d      = crc_nib(crc_q, 4'h0);
            byte_cnt_d = byte_inc;
          end else if (byte_cnt_q < MinBytes) begin
            pad_hi_d = 1'b0;
            crc_d    = crc_nib(crc_q, 4'h0);
          end else begin
            state_d   = StFcs;
            nib_cnt_d = 4'd0;
            rxd_d     = fcs[3:0];
          end
        end
        StFcs: begin
          if (nib_cnt_q == 4'd7) begin
            state_d     = StIfg;
            ifg_cnt_d   = IfgLast;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            nib_cnt_d = nib_nxt;
            rxd_d     = fcs[{nib_nxt[2:0], 2'b00} +: 4];
            dv_d      = 1'b1;
          end
        end
        StIfg: begin
          if (ifg_cnt_q == 16'd0) begin
            state_d = StIdle;
          end else begin
            ifg_cnt_d = ifg_cnt_q - 16'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= StIdle;
      nib_cnt_q   <= 4'd0;
      ifg_cnt_q   <= 16'd0;
      byte_cnt_q  <= 16'd0;
      crc_q       <= 32'hFFFFFFFF;
      data_q      <= 8'd0;
      last_q      <= 1'b0;
      pad_hi_q    <= 1'b0;
      frame_cnt_q <= 16'd0;
      rxd_q       <= 4'h0;
      dv_q        <= 1'b0;
      er_q        <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nib_cnt_q   <= nib_cnt_d;
      ifg_cnt_q   <= ifg_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      data_q      <= data_d;
      last_q      <= last_d;
      pad_hi_q    <= pad_hi_d;
      frame_cnt_q <= frame_cnt_d;
      rxd_q       <= rxd_d;
      dv_q        <= dv_d;
      er_q        <= er_d;
      und_q       <= und_d;
    end
  end

  assign s_ready_o   = fetch;
  assign mii_rxd_o   = rxd_q;
  assign mii_rx_dv_o = dv_q;
  assign mii_rx_er_o = er_q;
  assign busy_o      = (state_q != StIdle);
  assign frame_cnt_o = frame_cnt_q;
  assign underrun_o  = und_q;

endmodule

// File: tb/tb_iob_eth_mii_rx_gen.sv
// Scoreboard bench: instance 0 has padding disabled, instance 1 has padding enabled.
module tb_iob_eth_mii_rx_gen;

  localparam int Ifg = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst = 2'b11;
  logic [1:0][7:0]  s_data = '0;
  logic [1:0]       s_valid = '0;
  logic [1:0]       s_last = '0;
  wire  [1:0]       rdy, dv, er, busy, und;
  wire  [1:0][3:0]  rxd;
  wire  [1:0][15:0] fcnt;

  iob_eth_mii_rx_gen #(.PAD_EN(0), .IFG_NIB(Ifg)) u_dut0 (
    .clk_i(clk), .arst_i(rst[0]), .s_data_i(s_data[0]), .s_valid_i(s_valid[0]),
    .s_last_i(s_last[0]), .s_ready_o(rdy[0]), .mii_rxd_o(rxd[0]), .mii_rx_dv_o(dv[0]),
    .mii_rx_er_o(er[0]), .busy_o(busy[0]), .frame_cnt_o(fcnt[0]), .underrun_o(und[0])
  );

  iob_eth_mii_rx_gen #(.PAD_EN(1), .IFG_NIB(Ifg)) u_dut1 (
    .clk_i(clk), .arst_i(rst[1]), .s_data_i(s_data[1]), .s_valid_i(s_valid[1]),
    .s_last_i(s_last[1]), .s_ready_o(rdy[1]), .mii_rxd_o(rxd[1]), .mii_rx_dv_o(dv[1]),
    .mii_rx_er_o(er[1]), .busy_o(busy[1]), .frame_cnt_o(fcnt[1]), .underrun_o(und[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected {dv, er, rxd} for every cycle where a DUT drives dv or er.
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [7:0] pay[$];
  logic [7:0] sb[$];
  logic       sl[$];

  bit [1:0] mon_en = '0;
  bit [1:0] prev_pres = '0;
  int hi_run[2], hi_len[2], low_run[2], last_gap[2], rise_cyc[2];
  int ifg_cnt[2], ready_cnt[2], und_cnt[2], vr_cyc[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int s, input logic [5:0] v);
    if (s == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  function automatic logic [31:0] crc_ref(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c ^= {24'd0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_expect(input int s, input bit pad, input bit abort, input bit model_fcs);
    logic [7:0]  fr[$];
    logic [31:0] f;
    fr = pay;
    for (int i = 0; i < 15; i++) push(s, 6'h25);
    push(s, 6'h2D);
    foreach (pay[i]) begin
      push(s, {2'b10, pay[i][3:0]});
      push(s, {2'b10, pay[i][7:4]});
    end
    if (abort) begin
      push(s, 6'h30);
    end else begin
      if (pad) while (fr.size() < 60) begin
        fr.push_back(8'h00);
        push(s, 6'h20);
        push(s, 6'h20);
      end
      if (model_fcs) begin
        f = crc_ref(fr);
        for (int k = 0; k < 8; k++) push(s, {2'b10, f[4*k +: 4]});
      end
    end
  endtask

  task automatic stream_from_pay(input bit last_at_end);
    sb = pay;
    sl.delete();
    foreach (pay[i]) sl.push_back(last_at_end && (i == pay.size() - 1));
  endtask

  task automatic clear_stats(input int s);
    hi_run[s] = 0; hi_len[s] = 0; low_run[s] = 0; last_gap[s] = 0; rise_cyc[s] = 0;
    ifg_cnt[s] = 0; ready_cnt[s] = 0; und_cnt[s] = 0;
  endtask

  // Call just after a rising edge; returns once the stream is consumed.
  task automatic drive_stream(input int s);
    int idx = 0;
    int guard = 0;
    bit hs;
    s_valid[s] = 1'b1; s_data[s] = sb[0]; s_last[s] = sl[0];
    vr_cyc[s] = cyc;
    while (idx < sb.size()) begin
      @(negedge clk);
      hs = rdy[s];
      @(posedge clk); #1;
      if (hs) begin
        idx++;
        if (idx < sb.size()) begin
          s_data[s] = sb[idx]; s_last[s] = sl[idx];
        end
      end
      guard++;
      if (guard > 5000) begin
        check("drive_timeout", 32'(idx), 32'(sb.size()));
        break;
      end
    end
    s_valid[s] = 1'b0; s_data[s] = 8'h00; s_last[s] = 1'b0;
  endtask

  task automatic wait_idle(input int s);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(busy[s] == 1'b0 && qsize(s) == 0) && n < 5000);
    if (n >= 5000) check("idle_timeout", 32'(qsize(s)), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents dv or er.
  initial forever begin
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (mon_en[i]) begin
        logic [5:0] got, expv;
        bit pres;
        pres = dv[i] || er[i];
        if (pres) begin
          got = {dv[i], er[i], rxd[i]};
          if (qsize(i) == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_nibble dut%0d: got %0h expected none", i, got);
          end else begin
            expv = (i == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("nibble_dut%0d", i), 32'(got), 32'(expv));
          end
          if (!prev_pres[i]) begin
            rise_cyc[i] = cyc; last_gap[i] = low_run[i]; hi_run[i] = 0;
          end
          hi_run[i]++;
          low_run[i] = 0;
        end else begin
          if (prev_pres[i]) hi_len[i] = hi_run[i];
          low_run[i]++;
          if (busy[i]) ifg_cnt[i]++;
        end
        prev_pres[i] = pres;
        if (rdy[i]) ready_cnt[i]++;
        if (und[i]) und_cnt[i]++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hand;
    int n;
    repeat (3) @(posedge clk);
    #2 rst = 2'b00;
    @(negedge clk); #1;
    check("reset_dv", 32'(dv), 32'd0);
    check("reset_er", 32'(er), 32'd0);
    check("reset_rxd", 32'(rxd), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(rdy), 32'd0);
    check("reset_fcnt", 32'(fcnt), 32'd0);

    // Asynchronous reset while dut1 is in PAY_HI.
    @(posedge clk); #1;
    s_valid[1] = 1'b1; s_data[1] = 8'h3C; s_last[1] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!dv[1] && n < 100);
    repeat (17) @(negedge clk);
    check("payhi_nibble", 32'(rxd[1]), 32'h3);
    #2 rst[1] = 1'b1;
    #1;
    check("midreset_dv", 32'(dv[1]), 32'd0);
    check("midreset_er", 32'(er[1]), 32'd0);
    check("midreset_rxd", 32'(rxd[1]), 32'd0);
    s_valid[1] = 1'b0;
    @(posedge clk); #1 rst[1] = 1'b0;
    @(negedge clk); #1;
    check("postreset_busy", 32'(busy[1]), 32'd0);
    check("postreset_fcnt", 32'(fcnt[1]), 32'd0);
    @(posedge clk); #1;
    mon_en = 2'b11;

    // dut0, no padding: "123456789" with known CRC 0xCBF43926.
    clear_stats(0);
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    build_expect(0, 1'b0, 1'b0, 1'b0);
    hand = 32'hCBF43926;
    for (int k = 0; k < 8; k++) push(0, {2'b10, hand[4*k +: 4]});
    stream_from_pay(1'b1);
    drive_stream(0);
    wait_idle(0);
    check("ascii_dv_latency", 32'(rise_cyc[0]), 32'(vr_cyc[0] + 2));
    check("ascii_dv_len", 32'(hi_len[0]), 32'd42);
    check("ascii_ifg", 32'(ifg_cnt[0]), 32'(Ifg));
    check("ascii_fcnt", 32'(fcnt[0]), 32'd1);

    // dut1, padded single-byte frame.
    clear_stats(1);
    pay = '{8'hAB};
    build_expect(1, 1'b1, 1'b0, 1'b1);
    stream_from_pay(1'b1);
    drive_stream(1);
    wait_idle(1);
    check("pad_dv_len", 32'(hi_len[1]), 32'd144);
    check("pad_ifg", 32'(ifg_cnt[1]), 32'(Ifg));
    check("pad_fcnt", 32'(fcnt[1]), 32'd1);
    check("pad_ready", 32'(ready_cnt[1]), 32'd1);

    // dut1, underrun after 3 bytes of an intended 10-byte frame.
    clear_stats(1);
    pay = '{8'h10, 8'h21, 8'h32};
    build_expect(1, 1'b1, 1'b1, 1'b0);
    stream_from_pay(1'b0);
    drive_stream(1);
    wait_idle(1);
    check("und_pulses", 32'(und_cnt[1]), 32'd1);
    check("und_dv_len", 32'(hi_len[1]), 32'd23);
    check("und_ifg", 32'(ifg_cnt[1]), 32'(Ifg));
    check("und_fcnt", 32'(fcnt[1]), 32'd1);

    // dut1, two back-to-back 64-byte frames with valid held high.
    clear_stats(1);
    sb.delete(); sl.delete();
    for (int f = 0; f < 2; f++) begin
      pay.delete();
      for (int i = 0; i < 64; i++) pay.push_back(8'(i * 7 + f * 3 + 1));
      build_expect(1, 1'b1, 1'b0, 1'b1);
      foreach (pay[i]) begin
        sb.push_back(pay[i]);
        sl.push_back(i == 63);
      end
    end
    drive_stream(1);
    wait_idle(1);
    check("b2b_gap", 32'(last_gap[1]), 32'(Ifg + 1));
    check("b2b_ready", 32'(ready_cnt[1]), 32'd128);
    check("b2b_dv_len", 32'(hi_len[1]), 32'd152);
    check("b2b_fcnt", 32'(fcnt[1]), 32'd3);

    // Frame counter wrap.
    force u_dut1.frame_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release u_dut1.frame_cnt_q;
    @(negedge clk); #1;
    check("wrap_preset", 32'(fcnt[1]), 32'hFFFF);
    @(posedge clk); #1;
    pay = '{8'h5A};
    build_expect(1, 1'b1, 1'b0, 1'b1);
    stream_from_pay(1'b1);
    drive_stream(1);
    wait_idle(1);
    check("wrap_fcnt", 32'(fcnt[1]), 32'h0000);
    check("dut0_untouched", 32'(fcnt[0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
